// File: rtl/bsp_tx_stuffer.sv
// Transmit-side CAN bit stuffer with CRC-15 generation.
// Takes one unstuffed bit per bit time (SOF through the last data bit).
// After five equal bits it inserts a complementary stuff bit and raises
// halt so the bit source holds. The 15-bit CRC is then appended MSB first,
// with stuffing still applied.
module bsp_tx_stuffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock,
    input  logic        frame_start,
    input  logic        data_in,
    input  logic        data_last,
    input  logic        abort,
    output logic        tx_bit,
    output logic        halt,
    output logic        busy,
    output logic [14:0] crc,
    output logic        crc_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        CRC       = 2'd2,
        STUFF_END = 2'd3
    } state_t;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    state_t      state, state_nxt;
    logic [2:0]  run, run_nxt;        // length of the current run of equal line bits
    logic        last, last_nxt;      // value of the most recent line bit
    logic [3:0]  idx, idx_nxt;        // CRC bit currently being shifted out
    logic        tx_nxt;
    logic [14:0] crc_nxt;
    logic        done_nxt;

    logic        stuff;
    logic        src_bit;             // non-stuff bit that goes on the line this bit time
    logic [2:0]  run_adv;             // run length after src_bit is emitted

    // One CRC-15 shift for serial input bit b.
    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        return {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
    endfunction

    assign stuff   = ((state == DATA) || (state == CRC)) && (run == 3'd5);
    assign halt    = stuff;
    assign busy    = (state != IDLE);
    assign src_bit = (state == CRC) ? crc[idx] : data_in;
    // A non-stuff bit only occurs with run < 5, so run + 1 never passes 5.
    assign run_adv = (src_bit == last) ? run + 3'd1 : 3'd1;

    // Next-state and next-output computation for every register.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned; otherwise a latch is inferred.
        state_nxt = state;
        tx_nxt    = tx_bit;
        crc_nxt   = crc;
        run_nxt   = run;
        last_nxt  = last;
        idx_nxt   = idx;
        done_nxt  = 1'b0;

        if (abort) begin
            // Arbitration lost or error: drop the frame at once.
            // The CRC register is kept for inspection.
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            run_nxt   = 3'd0;
            last_nxt  = 1'b1;
            idx_nxt   = 4'd0;
        end else if (clock) begin
            unique case (state)
                IDLE: begin
                    tx_nxt = 1'b1;
                    if (frame_start) begin
                        // SOF is a dominant 0. Feeding it into a cleared CRC leaves 0.
                        tx_nxt    = 1'b0;
                        crc_nxt   = crc_step(15'h0000, 1'b0);
                        run_nxt   = 3'd1;
                        last_nxt  = 1'b0;
                        state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (stuff) begin
                        tx_nxt   = ~last;
                        run_nxt  = 3'd1;
                        last_nxt = ~last;
                    end else begin
                        tx_nxt   = data_in;
                        crc_nxt  = crc_step(crc, data_in);
                        run_nxt  = run_adv;
                        last_nxt = data_in;
                        if (data_last) begin
                            idx_nxt   = 4'd14;
                            state_nxt = CRC;
                        end
                    end
                end
                CRC: begin
                    if (stuff) begin
                        tx_nxt   = ~last;
                        run_nxt  = 3'd1;
                        last_nxt = ~last;
                    end else begin
                        tx_nxt   = src_bit;
                        run_nxt  = run_adv;
                        last_nxt = src_bit;
                        idx_nxt  = idx - 4'd1;
                        if (idx == 4'd0) begin
                            // A run of five ending the CRC still needs its stuff bit.
                            if (run_adv == 3'd5) begin
                                state_nxt = STUFF_END;
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end
                    end
                end
                STUFF_END: begin
                    tx_nxt    = ~last;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state    <= IDLE;
            tx_bit   <= 1'b1;
            crc      <= 15'h0000;
            crc_done <= 1'b0;
            run      <= 3'd0;
            last     <= 1'b1;
            idx      <= 4'd0;
        end else begin
            state    <= state_nxt;
            tx_bit   <= tx_nxt;
            crc      <= crc_nxt;
            crc_done <= done_nxt;
            run      <= run_nxt;
            last     <= last_nxt;
            idx      <= idx_nxt;
        end
    end

endmodule

// File: doc/bsp_tx_stuffer.md
# bsp_tx_stuffer

Transmit-side bit stuffer and CRC-15 generator for the Basic CAN controller. It sits between the bit stream processor's serial output and the transmit control logic. It takes one unstuffed bit per bit time (SOF through the last data bit) and inserts a complementary stuff bit after every five equal bits. While a stuff bit is on the line it holds the bit source via `halt`. After the last data bit it appends the 15-bit CAN CRC, MSB first, with stuffing still applied.

## Interface
No parameters.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; sampled on `clk` rising edge, overrides all other inputs
- clock  in  1  bit-time enable; all state changes except reset/abort require `clock`=1
- frame_start  in  1  start frame; sampled in IDLE with `clock`
- data_in  in  1  unstuffed serial bit from bit stream processor
- data_last  in  1  current `data_in` is final data bit; sampled only on non-stuff DATA bit times
- abort  in  1  arbitration lost / error; effective on any `clk` edge, needs no `clock`
- tx_bit  out  1  stuffed serial bit to line driver; 1 = recessive
- halt  out  1  stuff bit in this bit time; bit source must not advance
- busy  out  1  state != IDLE
- crc  out  15  running CRC register
- crc_done  out  1  one-`clk` pulse when the frame's final stuffed bit (last CRC bit, or the trailing stuff bit) is emitted

## Operation
- States: IDLE, DATA, CRC, STUFF_END. Internal: `run` (3 bit), `last` (1 bit), `idx` (4 bit).
- Reset values: state=IDLE, tx_bit=1, halt=0, busy=0, crc=0, crc_done=0, run=0, last=1, idx=0.
- `stuff` (combinational) = (state is DATA or CRC) and run==5.
- `halt` = `stuff` (combinational from registers).
- IDLE:
  - tx_bit=1.
  - On `clock`&frame_start: tx_bit<=0 (SOF), crc<=0, run<=1, last<=0, go to DATA.
  - SOF goes through the CRC update; with crc=0 the result is 0.
- DATA, on `clock`:
  - If `stuff`: tx_bit<=!last, run<=1, last<=!last. CRC, `data_last` and `data_in` are ignored.
  - Otherwise: tx_bit<=data_in and the CRC is updated with data_in. If data_in==last, run<=run+1; else run<=1, last<=data_in.
  - If data_last on a non-stuff bit: idx<=14, go to CRC.
- CRC update for bit b: nxt=b^crc[14]; crc<={crc[13:0],1'b0}^(nxt ? 15'h4599 : 0).
- CRC, on `clock`:
  - If `stuff`: emit stuff bit exactly as in DATA; idx is unchanged.
  - Otherwise: tx_bit<=crc[idx], the run/last update uses crc[idx], and idx<=idx-1. The CRC register is frozen during this state.
  - After emitting idx==0: if the resulting run==5, go to STUFF_END. Otherwise go to IDLE and pulse crc_done.
- STUFF_END, on `clock`: tx_bit<=!last, go to IDLE, pulse crc_done. halt=0 in this state.
- frame_start outside IDLE is ignored.
- abort has priority over everything except reset. On the next `clk` edge: state=IDLE, tx_bit=1, run=0, last=1, idx=0. No crc_done. The crc register keeps its value.
- reset mid-frame forces all reset values on that edge. This includes `crc`.
- `run` never exceeds 5.

## Timing
- tx_bit is registered and changes only on a `clk` edge where `clock`=1, or on abort/reset.
- The bit output in the bit time after sample *n* is a 1-bit-time latency.
- halt is valid throughout the bit time before the stuff bit is launched. The bit source samples halt together with `clock` on the same edge, so it holds its pointer for exactly one bit time per stuff bit.
- crc_done is asserted for exactly one `clk` cycle: the cycle after the edge that launched the final bit.
- A frame with K data bits (excluding SOF) and S stuff bits occupies 1+K+15+S bit times from SOF to crc_done.

## Test plan
- Reset check: assert reset for 2 clk. All outputs equal their reset values (tx_bit=1, crc=0, busy=0). frame_start with clock=0 causes no change.
- Minimal frame: SOF, then data 1 with data_last.
  - Required tx_bit sequence over 17 bit times: 0,1,1,0,0,0,1,0,1,1,0,0,1,1,0,0,1.
  - crc=15'h4599, halt never 1, crc_done pulses once after the last bit.
- Stuffing in data: SOF, then data 0,0,0,0,1,…
  - After SOF plus 4 zeros, halt=1 for one bit time and tx_bit=1 (stuff).
  - The source holds, and data bit 1 is emitted next.
  - crc excludes the stuff bit.
- Stuff at the DATA→CRC boundary: SOF, then data 1,1,1,1,1 with data_last on the fifth bit.
  - The first bit time of CRC is a stuff 0 with idx still 14.
  - The CRC bits follow unshifted.
- Abort mid-CRC: assert abort for one clk with clock=0 in CRC state.
  - Next clk: busy=0, tx_bit=1.
  - No crc_done, and a new frame_start is accepted on the next clock.
- Reset mid-DATA: reset asserted while halt=1.
  - On the same edge all outputs return to their reset values and halt=0.
